// File: rtl/palette_loader.sv
// Writable 16-entry RGB332 palette with a valid/ready streaming loader and a registered read port.
// Optional PALETTE_VBLANK_GATE_EN: loader only accepts bytes while vblank is high.
module palette_loader #(
  parameter int ENTRIES = 16,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        start_idx,
  input  logic [4:0]        count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  input  logic              vblank,
  input  logic [3:0]        rd_idx,
  output logic [DATA_W-1:0] rd_color
);

  // state | meaning
  // IDLE  | waiting for start; no bytes accepted
  // LOAD  | accepting stream bytes into consecutive entries
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [DATA_W-1:0] RESET_PAL [ENTRIES] = '{
    8'h00, 8'h07, 8'h66, 8'hEF, 8'h00, 8'hF8, 8'hEA, 8'h6F,
    8'h00, 8'h3F, 8'h00, 8'hC9, 8'h38, 8'hAA, 8'hAF, 8'hF6
  };

  state_t            state;
  logic [3:0]        wr_ptr;
  logic [4:0]        remaining;
  logic [DATA_W-1:0] pal [ENTRIES];

`ifdef PALETTE_VBLANK_GATE_EN
  // Hold off writes during active video so a frame never sees a half-loaded palette.
  assign in_ready = (state == LOAD) && vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign in_ready = (state == LOAD);
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      rd_color  <= '0;
      for (int i = 0; i < ENTRIES; i++) pal[i] <= RESET_PAL[i];
    end else begin
      // Nonblocking read: a same-cycle write to rd_idx returns the old colour.
      rd_color <= pal[rd_idx];
      case (state)
        IDLE: begin
          if (start) begin
            if (count == 5'd0) begin
              state <= DONE;
            end else begin
              wr_ptr    <= start_idx;
              remaining <= (count > 5'd16) ? 5'd16 : count;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            pal[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + 4'd1;
            remaining   <= remaining - 5'd1;
            if (remaining == 5'd1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
